// File: rtl/rdyacpt_pkg.sv
// Shared definitions for the rdy/acpt stream transmitter: state encoding and
// a helper that sizes the inter-word gap counter.
package rdyacpt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } tx_state_t;

  // Bits needed to hold a gap count up to and including 'gap'
  function automatic int gap_w(input int gap);
    if (gap <= 1) return 1;
    return $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/rdyacpt_gap_timer.sv
// Loadable down-counter that measures the idle cycles between words.
// It is loaded with the gap length minus one, so 'zero' marks the last idle cycle.
module rdyacpt_gap_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and stop at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rdyacpt_stream_tx.sv
// Transmitting end of the rdy/acpt handshake. A one-shot command produces an
// arithmetic sequence of words; every output is a flop, and rdy/data stay
// stable while the sink withholds acpt.
module rdyacpt_stream_tx
  import rdyacpt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] start_len,
  input  logic [WIDTH-1:0] start_data,
  input  logic [WIDTH-1:0] start_step,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] word_cnt,
  output logic             downstream_rdy,
  output logic [WIDTH-1:0] downstream_data,
  input  logic             downstream_acpt
);

  tx_state_t        state, state_n;
  logic [LEN_W-1:0] remaining, rem_n;
  logic [LEN_W-1:0] cnt_n;
  logic [WIDTH-1:0] step, step_n;
  logic [WIDTH-1:0] data_n;
  logic             rdy_n, busy_n, done_n;
  logic             gap_load, gap_dec, gap_zero;
  logic             transfer;

  assign transfer = downstream_rdy & downstream_acpt;
  assign gap_dec  = (state == S_GAP) && !gap_zero;

  // Gap timer only exists when idle cycles are requested
  generate
    if (GAP > 0) begin : g_timer
      localparam int GAP_W = gap_w(GAP);
      localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

      rdyacpt_gap_timer #(
        .W(GAP_W)
      ) u_gap_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (gap_load),
        .load_value(GAP_RELOAD),
        .dec       (gap_dec),
        .zero      (gap_zero)
      );
    end else begin : g_no_timer
      logic gap_unused;
      assign gap_zero   = 1'b1;
      assign gap_unused = gap_load ^ gap_dec;
    end
  endgenerate

  // State and output registers; reset discards any burst in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      remaining       <= '0;
      step            <= '0;
      word_cnt        <= '0;
      downstream_rdy  <= 1'b0;
      downstream_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      remaining       <= rem_n;
      step            <= step_n;
      word_cnt        <= cnt_n;
      downstream_rdy  <= rdy_n;
      downstream_data <= data_n;
      busy            <= busy_n;
      done            <= done_n;
    end
  end

  // Next-state and next-output logic; everything holds unless a branch changes it
  always_comb begin
    state_n  = state;
    rem_n    = remaining;
    step_n   = step;
    cnt_n    = word_cnt;
    rdy_n    = downstream_rdy;
    data_n   = downstream_data;
    busy_n   = busy;
    done_n   = 1'b0;
    gap_load = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_n = '0;
          if (start_len != '0) begin
            state_n = S_SEND;
            rem_n   = start_len;
            step_n  = start_step;
            rdy_n   = 1'b1;
            data_n  = start_data;
            busy_n  = 1'b1;
          end else begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (transfer) begin
          cnt_n = word_cnt + LEN_W'(1);
          rem_n = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_n = S_DONE;
            rdy_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else if (GAP > 0) begin
            state_n  = S_GAP;
            rdy_n    = 1'b0;
            gap_load = 1'b1;
          end else begin
            data_n = downstream_data + step;
          end
        end
      end

      S_GAP: begin
        if (gap_zero) begin
          state_n = S_SEND;
          rdy_n   = 1'b1;
          data_n  = downstream_data + step;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rdyacpt_stream_tx.sv
// Self-checking bench for rdyacpt_stream_tx: table-driven bursts on a GAP=0
// instance with a word scoreboard, plus hand-written corner sequences and a
// GAP=2 instance for idle-cycle timing.
module tb_rdyacpt_stream_tx;

  typedef struct {
    logic [7:0] len;
    logic [7:0] data;
    logic [7:0] step;
    int         mode;     // 0 acpt tied high, 1 stall 3 cycles on word 2, 2 random acpt
    int         exp_cyc;  // cycles from first rdy to done, -1 when not fixed
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       start = 1'b0;
  logic [7:0] start_len = '0, start_data = '0, start_step = '0;
  logic       acpt = 1'b0;
  logic       busy, done, rdy;
  logic [7:0] word_cnt, data;

  logic       g_start = 1'b0;
  logic [7:0] g_len = '0, g_data_in = '0, g_step = '0;
  logic       g_acpt = 1'b0;
  logic       g_busy, g_done, g_rdy;
  logic [7:0] g_word_cnt, g_data;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  vec_t       vecs[6];
  bit         gap_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  rdyacpt_stream_tx #(.WIDTH(8), .LEN_W(8), .GAP(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_len      (start_len),
    .start_data     (start_data),
    .start_step     (start_step),
    .busy           (busy),
    .done           (done),
    .word_cnt       (word_cnt),
    .downstream_rdy (rdy),
    .downstream_data(data),
    .downstream_acpt(acpt)
  );

  rdyacpt_stream_tx #(.WIDTH(8), .LEN_W(8), .GAP(2)) dut_gap (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (g_start),
    .start_len      (g_len),
    .start_data     (g_data_in),
    .start_step     (g_step),
    .busy           (g_busy),
    .done           (g_done),
    .word_cnt       (g_word_cnt),
    .downstream_rdy (g_rdy),
    .downstream_data(g_data),
    .downstream_acpt(g_acpt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the words a burst must deliver, in order
  task automatic push_burst(input logic [7:0] len, input logic [7:0] d0, input logic [7:0] s);
    logic [7:0] d;
    d = d0;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(d);
      d = d + s;
    end
  endtask

  // Issue one start command and record its expected words; returns in the first burst cycle
  task automatic apply_stimulus(input logic [7:0] len, input logic [7:0] d0, input logic [7:0] s);
    next_cycle();
    start      = 1'b1;
    start_len  = len;
    start_data = d0;
    start_step = s;
    push_burst(len, d0, s);
    next_cycle();
    start = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int         cyc;
    int         xfers;
    int         stall;
    logic [7:0] stall_exp;
    cyc       = 0;
    xfers     = 0;
    stall     = 0;
    stall_exp = v.data + v.step;
    apply_stimulus(v.len, v.data, v.step);
    check_output("start latency rdy", rdy, v.len != 0);
    check_output("start latency busy", busy, v.len != 0);
    while (!done && cyc < 300) begin
      case (v.mode)
        1: begin
          if (xfers == 1 && stall < 3) begin
            acpt = 1'b0;
            stall++;
            check_output("stall rdy", rdy, 1);
            check_output("stall data", data, stall_exp);
          end else begin
            acpt = 1'b1;
          end
        end
        2:       acpt = 1'($urandom_range(0, 1));
        default: acpt = 1'b1;
      endcase
      if (rdy && acpt) xfers++;
      cyc++;
      next_cycle();
    end
    acpt = 1'b0;
    check_output("done pulse", done, 1);
    if (v.exp_cyc >= 0) check_output("burst cycles", cyc, v.exp_cyc);
    check_output("busy on done", busy, 0);
    check_output("rdy on done", rdy, 0);
    check_output("word_cnt", word_cnt, v.len);
    check_output("scoreboard drained", exp_q.size(), 0);
    next_cycle();
    check_output("done one cycle", done, 0);
    check_output("word_cnt holds", word_cnt, v.len);
  endtask

  // Scoreboard: each transfer (rdy & acpt, sampled mid-cycle) pops one expected word
  always @(negedge clk) begin
    if (reset_n && rdy && acpt) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL word: got %0h expected none", data);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("word", data, mon_exp);
      end
    end
  end

  // Backpressure must hold rdy and data on both instances
  property p_hold(logic r, logic a, logic [7:0] d);
    @(posedge clk) disable iff (!reset_n) (r && !a) |=> (r && $stable(d));
  endproperty

  a_hold: assert property (p_hold(rdy, acpt, data))
    else begin
      errors++;
      $display("[TB] FAIL hold: rdy/data changed under backpressure at %0t", $time);
    end

  a_hold_gap: assert property (p_hold(g_rdy, g_acpt, g_data))
    else begin
      errors++;
      $display("[TB] FAIL hold_gap: rdy/data changed under backpressure at %0t", $time);
    end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    int         cyc;
    logic [7:0] gexp;

    vecs[0] = '{len: 8'd4, data: 8'h10, step: 8'h01, mode: 0, exp_cyc: 4};
    vecs[1] = '{len: 8'd4, data: 8'h10, step: 8'h01, mode: 1, exp_cyc: 7};
    vecs[2] = '{len: 8'd3, data: 8'hFE, step: 8'h01, mode: 0, exp_cyc: 3};
    vecs[3] = '{len: 8'd0, data: 8'h55, step: 8'h01, mode: 0, exp_cyc: 0};
    vecs[4] = '{len: 8'd1, data: 8'hAA, step: 8'h55, mode: 0, exp_cyc: 1};
    vecs[5] = '{len: 8'd9, data: 8'hF0, step: 8'h13, mode: 2, exp_cyc: -1};

    // Reset values while reset is held
    next_cycle();
    check_output("reset rdy", rdy, 0);
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset word_cnt", word_cnt, 0);
    check_output("reset data", data, 0);
    reset_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i]);
    end

    // start while busy and on the done cycle must be ignored
    acpt = 1'b1;
    apply_stimulus(8'd3, 8'h20, 8'h02);
    start      = 1'b1;
    start_len  = 8'd9;
    start_data = 8'h77;
    next_cycle();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 50) begin
      next_cycle();
      cyc++;
    end
    check_output("ignored start done", done, 1);
    check_output("ignored start cycles", cyc, 3);
    check_output("ignored start busy on done", busy, 0);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    acpt  = 1'b0;
    check_output("no queued start rdy", rdy, 0);
    check_output("no queued start busy", busy, 0);
    next_cycle();
    check_output("idle after done rdy", rdy, 0);
    check_output("idle after done word_cnt", word_cnt, 3);
    check_output("ignored start scoreboard", exp_q.size(), 0);

    // Async reset mid-burst while stalled
    acpt = 1'b0;
    apply_stimulus(8'd5, 8'h40, 8'h01);
    next_cycle();
    check_output("pre-reset rdy", rdy, 1);
    check_output("pre-reset data", data, 8'h40);
    #2 reset_n = 1'b0;
    #1;
    check_output("async reset rdy", rdy, 0);
    check_output("async reset busy", busy, 0);
    check_output("async reset data", data, 0);
    exp_q.delete();
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output("post-reset rdy", rdy, 0);
      check_output("post-reset busy", busy, 0);
      check_output("post-reset done", done, 0);
    end
    run_vector(vecs[0]);

    // GAP=2 instance: two rdy-low cycles between words
    g_acpt = 1'b1;
    next_cycle();
    g_start   = 1'b1;
    g_len     = 8'd3;
    g_data_in = 8'h10;
    g_step    = 8'h01;
    next_cycle();
    g_start = 1'b0;
    gexp    = 8'h10;
    for (int i = 0; i < 7; i++) begin
      check_output("gap rdy pattern", g_rdy, gap_pat[i]);
      if (gap_pat[i]) begin
        check_output("gap data", g_data, gexp);
        gexp = gexp + 8'h01;
      end
      next_cycle();
    end
    check_output("gap done", g_done, 1);
    check_output("gap word_cnt", g_word_cnt, 3);
    check_output("gap busy on done", g_busy, 0);
    g_acpt = 1'b0;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
